// File: rtl/tproj_sched_pkg.sv
// Shared types, default sizes and count clamping for the TPROJ read scheduler.
package tproj_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int NIN_D        = 8;
  localparam int DATA_W_D     = 60;
  localparam int ADDR_W_D     = 8;
  localparam int MAX_CYCLES_D = 108;

  // A page holds at most lim entries; larger counts are treated as a full page.
  function automatic logic [15:0] clamp_count(input logic [7:0] n, input logic [15:0] lim);
    return ({8'd0, n} > lim) ? lim : {8'd0, n};
  endfunction

endpackage

// File: rtl/tproj_read_scheduler_if.sv
// Memory read bus and merged projection stream of the TPROJ read scheduler.
interface tproj_read_scheduler_if
  import tproj_sched_pkg::*;
#(
  parameter int NIN    = NIN_D,
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
);
  logic [NIN-1:0]             rd_en;
  logic [NIN-1:0][ADDR_W-1:0] rd_addr;
  logic [NIN-1:0][DATA_W-1:0] rd_dout;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [2:0]                 out_src;

  modport master (output rd_en, rd_addr, out_valid, out_data, out_src,
                  input  rd_dout, out_ready);
  modport slave  (input  rd_en, rd_addr, out_valid, out_data, out_src,
                  output rd_dout, out_ready);
endinterface

// File: rtl/tproj_grant_arb.sv
// Combinational grant for the TPROJ scheduler: request mask -> one-hot grant + index.
// TPROJ_SCHED_ROUND_ROBIN_EN selects a round-robin search starting at ptr;
// otherwise the lowest requesting index wins.
module tproj_grant_arb #(
  parameter int NIN = 8,
  parameter int IW  = (NIN > 1) ? $clog2(NIN) : 1
)(
  input  logic [NIN-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NIN-1:0] gnt,
  output logic [IW-1:0]  idx
);
  logic          found;
  logic [IW-1:0] j;

`ifndef TPROJ_SCHED_ROUND_ROBIN_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // First requester in search order gets the grant.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NIN; k++) begin
`ifdef TPROJ_SCHED_ROUND_ROBIN_EN
      j = ptr + IW'(k);
`else
      j = IW'(k);
`endif
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/tproj_read_scheduler.sv
// TPROJ read scheduler: drains eight input memories into one tagged stream per bx,
// bounded by a cycle budget. Optional macro TPROJ_SCHED_ROUND_ROBIN_EN switches the
// arbiter from fixed priority to round-robin.
module tproj_read_scheduler
  import tproj_sched_pkg::*;
#(
  parameter int NIN        = NIN_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int MAX_CYCLES = MAX_CYCLES_D
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          bx_in,
  input  logic [NIN-1:0][7:0] nent_0,
  input  logic [NIN-1:0][7:0] nent_1,
  output logic [2:0]          bx_out,
  output logic                done,
  output logic                truncated,
  tproj_read_scheduler_if.master bus
);
  localparam int          IW      = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [15:0] CNT_LIM = 16'(1) << (ADDR_W - 1);

  state_t                     state, nxt;
  logic                       page, trunc_r;
  logic [2:0]                 bx_lat;
  logic [NIN-1:0][ADDR_W-1:0] cnt, ld_cnt;
  logic [NIN-1:0][ADDR_W-2:0] idx;
  logic [NIN-1:0]             rem, gnt;
  logic [6:0]                 cyc;
  logic [IW-1:0]              ptr, gidx;
  logic                       budget_hit, stall, issue;
  // return pipe (rv), output register (ov) and skid buffer (sv)
  logic                       rv, ov, sv;
  logic [IW-1:0]              rsrc, os, ss;
  logic [DATA_W-1:0]          od, sd, win;

  tproj_grant_arb #(.NIN(NIN), .IW(IW)) u_arb (
    .req (rem),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  assign budget_hit = (cyc == 7'(MAX_CYCLES));
  assign stall      = sv | (rv & ~bus.out_ready);
  assign issue      = (state == S_RUN) & (|rem) & ~stall & ~budget_hit;
  assign win        = bus.rd_dout[rsrc];
  assign done       = (state == S_DONE);
  assign truncated  = done & trunc_r;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_src   = 3'(os);

  // Read strobes and addresses; idle lanes present address 0.
  always_comb begin
    bus.rd_en   = issue ? gnt : '0;
    bus.rd_addr = '0;
    for (int i = 0; i < NIN; i++)
      if (issue && gnt[i]) bus.rd_addr[i] = {page, idx[i]};
  end

  // Page-selected entry counts, clamped to one page.
  always_comb begin
    ld_cnt = '0;
    for (int i = 0; i < NIN; i++)
      ld_cnt[i] = ADDR_W'(clamp_count(bx_in[0] ? nent_1[i] : nent_0[i], CNT_LIM));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state: RUN ends on empty inputs or budget; DRAIN waits for every word to leave.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_LOAD;
      S_LOAD:  nxt = S_RUN;
      S_RUN:   if (!(|rem) || budget_hit) nxt = S_DRAIN;
      S_DRAIN: if (!rv && !sv && (!ov || bus.out_ready)) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Per-bx bookkeeping: counts, indices, budget counter, RR pointer, result flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      page    <= 1'b0;
      bx_lat  <= '0;
      bx_out  <= '0;
      trunc_r <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      rem     <= '0;
      cyc     <= '0;
      ptr     <= '0;
    end else begin
      if (state == S_LOAD) begin
        page   <= bx_in[0];
        bx_lat <= bx_in;
        cyc    <= '0;
        ptr    <= '0;
        idx    <= '0;
        cnt    <= ld_cnt;
        for (int i = 0; i < NIN; i++) rem[i] <= (ld_cnt[i] != '0);
      end
      if (state == S_RUN) begin
        if (cyc != '1) cyc <= cyc + 7'd1;
        if (issue) begin
          idx[gidx] <= idx[gidx] + (ADDR_W-1)'(1);
          if (({1'b0, idx[gidx]} + ADDR_W'(1)) == cnt[gidx]) rem[gidx] <= 1'b0;
          ptr <= gidx + IW'(1);
        end
        if (nxt == S_DRAIN) trunc_r <= |rem;
      end
      if (state == S_DRAIN && nxt == S_DONE) bx_out <= bx_lat;
    end
  end

  // Return pipe, output register and skid buffer; skid drains ahead of new data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rv <= 1'b0; rsrc <= '0;
      ov <= 1'b0; od <= '0; os <= '0;
      sv <= 1'b0; sd <= '0; ss <= '0;
    end else begin
      rv   <= issue;
      rsrc <= gidx;
      if (!ov || bus.out_ready) begin
        if (sv) begin
          ov <= 1'b1; od <= sd; os <= ss;
          sv <= rv;   sd <= win; ss <= rsrc;
        end else if (rv) begin
          ov <= 1'b1; od <= win; os <= rsrc;
        end else begin
          ov <= 1'b0;
        end
      end else if (rv) begin
        sv <= 1'b1; sd <= win; ss <= rsrc;
      end
    end
  end
endmodule

// File: tb/tb_tproj_read_scheduler.sv
// Self-checking bench for tproj_read_scheduler: memory model, ready driver, scoreboard.
module tb_tproj_read_scheduler;
  import tproj_sched_pkg::*;
  localparam int NIN = 8, DATA_W = 60, ADDR_W = 8, MAX_CYCLES = 108;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] bx_in = '0;
  logic [NIN-1:0][7:0] nent_0 = '0, nent_1 = '0;
  logic [2:0] bx_out;
  logic done, truncated;

  tproj_read_scheduler_if #(.NIN(NIN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  tproj_read_scheduler #(.NIN(NIN), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .bx_in(bx_in),
    .nent_0(nent_0), .nent_1(nent_1), .bx_out(bx_out),
    .done(done), .truncated(truncated), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_issue = 0, n_acc = 0;
  bit mon_en = 1'b0;
  int rdy_mode = 0, rdy_phase = 0;

  typedef struct { int src; logic [ADDR_W-1:0] addr; } rd_t;
  typedef struct { int src; logic [DATA_W-1:0] data; } wd_t;
  rd_t exp_rd[$];
  wd_t exp_out[$];
  rd_t mon_e;
  wd_t mon_w;
  logic prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_d;
  logic [2:0] prev_s;

  function automatic logic [DATA_W-1:0] mem_word(input int i, input logic [ADDR_W-1:0] a);
    return {4'hA, 8'(i), a, 40'h12_3456_789A};
  endfunction

  // Memories: one-cycle read latency.
  always @(posedge clk)
    for (int i = 0; i < NIN; i++)
      if (bus.rd_en[i] === 1'b1) bus.rd_dout[i] <= mem_word(i, bus.rd_addr[i]);

  // Downstream ready: 0 always 1, 1 pattern 1,0,0,1, 2 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin bus.out_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3); rdy_phase++; end
      2: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Monitor: read issues, hold stability, delivered words against the scoreboard.
  always @(negedge clk) if (mon_en) begin
    if (bus.rd_en != '0) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++; $display("FAIL rd_extra: rd_en=%b with no read expected", bus.rd_en);
      end else begin
        mon_e = exp_rd.pop_front();
        if (bus.rd_en !== (NIN'(1) << mon_e.src) || bus.rd_addr[mon_e.src] !== mon_e.addr) begin
          errors++;
          $display("FAIL rd_issue: got en=%b addr=%h, expected src=%0d addr=%h",
                   bus.rd_en, bus.rd_addr[mon_e.src], mon_e.src, mon_e.addr);
        end
      end
      checks++;
      if (n_issue - n_acc > 2) begin
        errors++; $display("FAIL rd_stall: issued with %0d words buffered, expected at most 2", n_issue - n_acc);
      end
      n_issue++;
    end
    if (prev_hold) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== prev_d || bus.out_src !== prev_s) begin
        errors++; $display("FAIL out_hold: got v=%b d=%h s=%0d, expected v=1 d=%h s=%0d",
                           bus.out_valid, bus.out_data, bus.out_src, prev_d, prev_s);
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (exp_out.size() == 0) begin
        errors++; $display("FAIL out_extra: word %h src %0d not expected", bus.out_data, bus.out_src);
      end else begin
        mon_w = exp_out.pop_front();
        if (bus.out_src !== 3'(mon_w.src) || bus.out_data !== mon_w.data) begin
          errors++; $display("FAIL out_word: got s=%0d d=%h, expected s=%0d d=%h",
                             bus.out_src, bus.out_data, mon_w.src, mon_w.data);
        end
      end
      n_acc++;
    end
    prev_hold = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
    prev_d = bus.out_data;
    prev_s = bus.out_src;
  end

  // Reference arbitration: pushes the expected issue order, returns issue count.
  task automatic build_expected(input logic [NIN-1:0][7:0] cnts, input logic page,
                                input int limit, output int n);
    int left[NIN];
    int ix[NIN];
    int ptr = 0;
    int g;
    rd_t r;
    wd_t w;
    n = 0;
    for (int i = 0; i < NIN; i++) begin
      left[i] = (int'(cnts[i]) > 128) ? 128 : int'(cnts[i]);
      ix[i] = 0;
    end
    while (n < limit) begin
      g = -1;
      for (int k = 0; k < NIN; k++) begin
`ifdef TPROJ_SCHED_ROUND_ROBIN_EN
        if (g < 0 && left[(ptr + k) % NIN] > 0) g = (ptr + k) % NIN;
`else
        if (g < 0 && left[k] > 0) g = k;
`endif
      end
      if (g < 0) break;
      r.src = g; r.addr = {page, 7'(ix[g])};
      w.src = g; w.data = mem_word(g, r.addr);
      exp_rd.push_back(r);
      exp_out.push_back(w);
      ix[g]++; left[g]--; ptr = (g + 1) % NIN; n++;
    end
  endtask

  // Pulse start, wait (bounded) for done; optional stray start at cycle 'extra'.
  task automatic run_bx(input logic [2:0] bx, input int extra,
                        output int lat, output logic tr, output logic [2:0] bxo);
    lat = -1; tr = 1'bx; bxo = 'x;
    @(posedge clk); #1 bx_in = bx; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      start = (k == extra);
      if (done === 1'b1) begin lat = k; tr = truncated; bxo = bx_out; break; end
    end
    start = 1'b0;
    checks++;
    if (lat < 0) begin errors++; $display("FAIL done_timeout: no done within 2000 cycles, expected done"); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b one cycle later, expected 0", done); end
    checks++;
    if (exp_out.size() != 0 || exp_rd.size() != 0) begin
      errors++; $display("FAIL pending: %0d reads %0d words outstanding at done, expected 0",
                         exp_rd.size(), exp_out.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || truncated !== 1'b0 || bx_out !== 3'd0 || bus.rd_en !== '0 ||
        bus.rd_addr !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_src !== 3'd0) begin
      errors++; $display("FAIL reset_state: done=%b tr=%b bx=%0d en=%b v=%b d=%h s=%0d, expected all 0",
                         done, truncated, bx_out, bus.rd_en, bus.out_valid, bus.out_data, bus.out_src);
    end
    @(posedge clk); #1 reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_fixed_priority();
    int n, lat, i0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_0[0] = 8'd3; nent_0[5] = 8'd2;
    build_expected(nent_0, 1'b0, 1000, n);
    i0 = n_issue;
    run_bx(3'd2, -1, lat, tr, bxo);
    checks++; if (n_issue - i0 !== 5) begin errors++; $display("FAIL prio_count: %0d issues, expected 5", n_issue - i0); end
    checks++; if (tr !== 1'b0) begin errors++; $display("FAIL prio_trunc: truncated=%b, expected 0", tr); end
    checks++; if (bxo !== 3'd2) begin errors++; $display("FAIL prio_bx: bx_out=%0d, expected 2", bxo); end
  endtask

  task automatic test_page_select();
    int n, lat, i0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_1[3] = 8'd2; nent_0[3] = 8'd9;
    build_expected(nent_1, 1'b1, 1000, n);
    i0 = n_issue;
    run_bx(3'd1, -1, lat, tr, bxo);
    checks++; if (n_issue - i0 !== 2) begin errors++; $display("FAIL page_count: %0d issues, expected 2", n_issue - i0); end
    checks++; if (bxo !== 3'd1) begin errors++; $display("FAIL page_bx: bx_out=%0d, expected 1", bxo); end
  endtask

  task automatic test_backpressure();
    int n, lat, a0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_0[2] = 8'd4;
    build_expected(nent_0, 1'b0, 1000, n);
    a0 = n_acc; rdy_phase = 0; rdy_mode = 1;
    run_bx(3'd0, -1, lat, tr, bxo);
    rdy_mode = 0;
    checks++; if (n_acc - a0 !== 4) begin errors++; $display("FAIL bp_count: %0d words, expected 4", n_acc - a0); end
    checks++; if (tr !== 1'b0) begin errors++; $display("FAIL bp_trunc: truncated=%b, expected 0", tr); end
  endtask

  task automatic test_budget();
    int n, lat, i0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_0[0] = 8'd100; nent_0[1] = 8'd100;
    build_expected(nent_0, 1'b0, MAX_CYCLES, n);
    i0 = n_issue;
    run_bx(3'd4, -1, lat, tr, bxo);
    checks++; if (n_issue - i0 !== 108) begin errors++; $display("FAIL budget_count: %0d issues, expected 108", n_issue - i0); end
    checks++; if (tr !== 1'b1) begin errors++; $display("FAIL budget_trunc: truncated=%b, expected 1", tr); end
    checks++; if (bxo !== 3'd4) begin errors++; $display("FAIL budget_bx: bx_out=%0d, expected 4", bxo); end
  endtask

  task automatic test_zero_entry();
    int lat, i0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0;
    i0 = n_issue;
    run_bx(3'd6, -1, lat, tr, bxo);
    checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency: done after %0d cycles, expected 3", lat); end
    checks++; if (n_issue - i0 !== 0) begin errors++; $display("FAIL zero_count: %0d issues, expected 0", n_issue - i0); end
    checks++; if (tr !== 1'b0 || bxo !== 3'd6) begin errors++; $display("FAIL zero_flags: tr=%b bx=%0d, expected 0/6", tr, bxo); end
  endtask

  task automatic test_reset_mid_run();
    int n, lat; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_0[0] = 8'd50;
    mon_en = 1'b0;
    @(posedge clk); #1 bx_in = 3'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || truncated !== 1'b0 || bx_out !== 3'd0 || bus.rd_en !== '0 ||
        bus.rd_addr !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_src !== 3'd0) begin
      errors++; $display("FAIL midreset_state: done=%b en=%b v=%b d=%h, expected all 0",
                         done, bus.rd_en, bus.out_valid, bus.out_data);
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.rd_en !== '0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: en=%b v=%b, expected 0/0", bus.rd_en, bus.out_valid);
    end
    exp_rd.delete(); exp_out.delete();
    mon_en = 1'b1;
    nent_0 = '0; nent_1[6] = 8'd3;
    build_expected(nent_1, 1'b1, 1000, n);
    run_bx(3'd5, -1, lat, tr, bxo);
    checks++; if (bxo !== 3'd5 || tr !== 1'b0) begin errors++; $display("FAIL midreset_rerun: bx=%0d tr=%b, expected 5/0", bxo, tr); end
  endtask

  task automatic test_round_robin();
    int n, lat, i0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_0[1] = 8'd2; nent_0[4] = 8'd2;
    build_expected(nent_0, 1'b0, 1000, n);
    i0 = n_issue;
    run_bx(3'd0, -1, lat, tr, bxo);
    checks++; if (n_issue - i0 !== 4) begin errors++; $display("FAIL rr_count: %0d issues, expected 4", n_issue - i0); end
  endtask

  task automatic test_random_backpressure();
    int n, lat, a0; logic tr; logic [2:0] bxo;
    nent_0 = '0; nent_1 = '0; nent_1[1] = 8'd3; nent_1[6] = 8'd5; nent_1[7] = 8'd2;
    build_expected(nent_1, 1'b1, 1000, n);
    a0 = n_acc; rdy_mode = 2;
    run_bx(3'd7, 3, lat, tr, bxo);
    rdy_mode = 0;
    checks++; if (n_acc - a0 !== 10) begin errors++; $display("FAIL rand_count: %0d words, expected 10", n_acc - a0); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stray_start: done=%b after run, expected 0", done); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed_priority();
    test_page_select();
    test_backpressure();
    test_budget();
    test_zero_entry();
    test_reset_mid_run();
    test_round_robin();
    test_random_backpressure();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
